cog_ctrx: RTL and testbench

//  Multi-channel successor to the cog counter: CHANNELS independent NCO/duty/edge/logic counters per cog,

---
 rtl/cog_ctrx.sv | 204 ++++++++++++++++++++
 tb/tb_cog_ctrx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cog_ctrx.sv
// cog_ctrx: multi-channel cog counter (NCO/duty/edge/logic modes)
// with a per-channel period / pulse-width capture unit.
module cog_ctrx #(
  parameter int CHANNELS = 2,
  parameter int W        = 32,
  parameter int PINS     = 32
) (
  input  logic                clk_cog,
  input  logic                res,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] sel,
  input  logic                setctr,
  input  logic                setfrq,
  input  logic                setphs,
  input  logic [W-1:0]        data,
  input  logic [PINS-1:0]     pin_in,
  input  logic                rd_cap,
  output logic [W-1:0]        phs,
  output logic [W-1:0]        cap,
  output logic [CHANNELS-1:0] cap_new,
  output logic [CHANNELS-1:0] cap_ovf,
  output logic [PINS-1:0]     pin_out
);
  localparam int PB = (PINS > 1) ? $clog2(PINS) : 1;

  logic [W-1:0]    phs_a  [CHANNELS];
  logic [W-1:0]    cap_a  [CHANNELS];
  logic [PINS-1:0] pins_a [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [31:0]     ctr_q, ctr_d;
    logic [W-1:0]    frq_q, frq_d;
    logic [W-1:0]    phs_q, phs_d;
    logic [W-1:0]    cap_q, cap_d;
    logic            carry_q, carry_d;
    logic [1:0]      dly_q, dly_d;
    logic            bdly_q, bdly_d;
    logic            new_q, new_d;
    logic            ovf_q, ovf_d;
    logic            hit, rdclr;
    logic [4:0]      mode;
    logic [3:0]      tt;
    logic [PB-1:0]   apin, bpin;
    logic [PINS-1:0] ash, bsh;
    logic            a, pos, neg;
    logic [W:0]      sum;
    logic            trig, out_a, out_b;
    logic            cap_ev, restart;
    logic [W-1:0]    cap_val, rst_val;
    logic            unused_c;

    assign hit   = (32'(sel) == 32'(c));
    assign rdclr = hit && rd_cap;
    assign mode  = ctr_q[30:26];
    assign tt    = ctr_q[25:22];
    assign apin  = ctr_q[PB-1:0];
    assign bpin  = ctr_q[9 +: PB];
    assign ash   = pin_in >> apin;
    assign bsh   = pin_in >> bpin;
    assign a     = dly_q[0];
    assign pos   = (dly_q == 2'b01);
    assign neg   = (dly_q == 2'b10);
    assign sum   = {1'b0, phs_q} + {1'b0, frq_q};
    assign unused_c = ^{ash[PINS-1:1], bsh[PINS-1:1], ctr_q};

    // Mode decode: accumulate trigger, pin outputs, capture events.
    always_comb begin
      trig    = 1'b0;
      out_a   = 1'b0;
      out_b   = 1'b0;
      cap_ev  = 1'b0;
      restart = 1'b0;
      cap_val = phs_q;
      rst_val = '0;
      case (mode)
        5'd1: begin trig = 1'b1; out_a = phs_q[W-1]; end
        5'd2: begin
          trig  = 1'b1;
          out_a = phs_q[W-1];
          out_b = ~phs_q[W-1];
        end
        5'd3: begin trig = 1'b1; out_a = carry_q; end
        5'd4: begin
          trig  = 1'b1;
          out_a = carry_q;
          out_b = ~carry_q;
        end
        5'd5:  trig = a;
        5'd6:  begin trig = a; out_b = ~a; end
        5'd7:  trig = ~a;
        5'd8:  begin trig = ~a; out_b = ~a; end
        5'd9:  trig = pos;
        5'd10: begin trig = pos; out_b = ~a; end
        5'd11: trig = neg;
        5'd12: begin trig = neg; out_b = ~a; end
        5'd13: begin
          if (pos) begin
            cap_ev  = 1'b1;
            restart = 1'b1;
            rst_val = frq_q;
          end else begin
            trig = 1'b1;
          end
        end
        5'd14: begin
          trig = a;
          if (neg) begin
            cap_ev  = 1'b1;
            restart = 1'b1;
            cap_val = sum[W-1:0];
          end
        end
        5'd15: trig = tt[{bdly_q, a}];
        default: ;
      endcase
    end

    // Next state: writes, restart and accumulate in priority order.
    always_comb begin
      ctr_d   = ctr_q;
      frq_d   = frq_q;
      phs_d   = phs_q;
      cap_d   = cap_q;
      carry_d = carry_q;
      dly_d   = dly_q;
      bdly_d  = bdly_q;
      new_d   = new_q;
      ovf_d   = ovf_q;
      if (mode != 5'd0) begin
        dly_d  = {dly_q[0], ash[0]};
        bdly_d = bsh[0];
      end
      if (hit && setphs) begin
        phs_d = data;
      end else if (restart) begin
        phs_d = rst_val;
      end else if (trig) begin
        {carry_d, phs_d} = sum;
      end
      if (cap_ev) begin
        cap_d = cap_val;
        new_d = 1'b1;
      end else if (rdclr) begin
        new_d = 1'b0;
      end
      if (cap_ev && new_q && !rdclr) ovf_d = 1'b1;
      if (hit && setfrq) frq_d = data;
      if (hit && setctr) begin
        ctr_d   = data[31:0];
        dly_d   = 2'b00;
        bdly_d  = 1'b0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
    end

    // Channel state register with synchronous reset.
    always_ff @(posedge clk_cog) begin
      if (res) begin
        ctr_q   <= '0;
        frq_q   <= '0;
        phs_q   <= '0;
        cap_q   <= '0;
        carry_q <= 1'b0;
        dly_q   <= 2'b00;
        bdly_q  <= 1'b0;
        new_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        ctr_q   <= ctr_d;
        frq_q   <= frq_d;
        phs_q   <= phs_d;
        cap_q   <= cap_d;
        carry_q <= carry_d;
        dly_q   <= dly_d;
        bdly_q  <= bdly_d;
        new_q   <= new_d;
        ovf_q   <= ovf_d;
      end
    end

    assign phs_a[c]  = phs_q;
    assign cap_a[c]  = cap_q;
    assign pins_a[c] = (PINS'(out_a) << apin) | (PINS'(out_b) << bpin);
    assign cap_new[c] = new_q;
    assign cap_ovf[c] = ovf_q;
  end

  logic unused_top;
  assign unused_top = ^data;

  // Read mux by sel and OR of all channel pin outputs.
  always_comb begin
    phs     = '0;
    cap     = '0;
    pin_out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (32'(sel) == 32'(i)) begin
        phs = phs_a[i];
        cap = cap_a[i];
      end
      pin_out = pin_out | pins_a[i];
    end
  end
endmodule

// File: tb/tb_cog_ctrx.sv
// tb_cog_ctrx: directed + random stimulus against a
// behavioural multi-channel counter model.
module tb_cog_ctrx;
  localparam int CH   = 2;
  localparam int W    = 32;
  localparam int PINS = 32;

  logic            clk = 1'b0;
  logic            res = 1'b1;
  logic            sel = 1'b0;
  logic            setctr = 1'b0;
  logic            setfrq = 1'b0;
  logic            setphs = 1'b0;
  logic [W-1:0]    data = '0;
  logic [PINS-1:0] pin_in = '0;
  logic            rd_cap = 1'b0;
  logic [W-1:0]    phs, cap;
  logic [CH-1:0]   cap_new, cap_ovf;
  logic [PINS-1:0] pin_out;

  cog_ctrx #(.CHANNELS(CH), .W(W), .PINS(PINS)) dut (
    .clk_cog(clk), .res(res), .sel(sel),
    .setctr(setctr), .setfrq(setfrq), .setphs(setphs),
    .data(data), .pin_in(pin_in), .rd_cap(rd_cap),
    .phs(phs), .cap(cap), .cap_new(cap_new),
    .cap_ovf(cap_ovf), .pin_out(pin_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]  m_ctr [CH];
  logic [W-1:0] m_frq [CH];
  logic [W-1:0] m_phs [CH];
  logic [W-1:0] m_cap [CH];
  bit m_c [CH], m_a0 [CH], m_a1 [CH], m_b [CH];
  bit m_new [CH], m_ovf [CH];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_capev(input int c);
    int m;
    m = int'(m_ctr[c][30:26]);
    return (m == 13 && !m_a1[c] && m_a0[c]) ||
           (m == 14 && m_a1[c] && !m_a0[c]);
  endfunction

  function automatic logic [PINS-1:0] m_pins();
    logic [PINS-1:0] p;
    int m;
    bit msb, oa, ob;
    p = '0;
    for (int c = 0; c < CH; c++) begin
      m = int'(m_ctr[c][30:26]);
      msb = m_phs[c][W-1];
      oa = 0;
      ob = 0;
      if (m == 1 || m == 2) oa = msb;
      if (m == 3 || m == 4) oa = m_c[c];
      if (m == 2) ob = !msb;
      if (m == 4) ob = !m_c[c];
      if (m inside {6, 8, 10, 12}) ob = !m_a0[c];
      if (oa) p[m_ctr[c][4:0]] = 1'b1;
      if (ob) p[m_ctr[c][13:9]] = 1'b1;
    end
    return p;
  endfunction

  task automatic model_step();
    int m;
    bit hit, a, rise, fall, trig, capev, rdhit;
    longint unsigned sum;
    logic [W-1:0] nphs;
    bit ncarry;
    if (res) begin
      for (int c = 0; c < CH; c++) begin
        m_ctr[c] = '0; m_frq[c] = '0; m_phs[c] = '0; m_cap[c] = '0;
        m_c[c] = 0; m_a0[c] = 0; m_a1[c] = 0; m_b[c] = 0;
        m_new[c] = 0; m_ovf[c] = 0;
      end
      return;
    end
    for (int c = 0; c < CH; c++) begin
      hit = (int'(sel) == c);
      rdhit = hit && rd_cap;
      m = int'(m_ctr[c][30:26]);
      a = m_a0[c];
      rise = !m_a1[c] && a;
      fall = m_a1[c] && !a;
      sum = longint'(m_phs[c]) + longint'(m_frq[c]);
      trig = 0;
      if (m >= 1 && m <= 4) trig = 1;
      else if (m == 5 || m == 6) trig = a;
      else if (m == 7 || m == 8) trig = !a;
      else if (m == 9 || m == 10) trig = rise;
      else if (m == 11 || m == 12) trig = fall;
      else if (m == 13) trig = !rise;
      else if (m == 14) trig = a;
      else if (m == 15) trig = m_ctr[c][22 + 2 * int'(m_b[c]) + int'(a)];
      capev = m_capev(c);
      nphs = m_phs[c];
      ncarry = m_c[c];
      if (hit && setphs) nphs = data;
      else if (capev) nphs = (m == 13) ? m_frq[c] : '0;
      else if (trig) begin
        nphs = W'(sum);
        ncarry = bit'(sum >> W);
      end
      if (capev) begin
        m_cap[c] = (m == 13) ? m_phs[c] : W'(sum);
        if (m_new[c] && !rdhit) m_ovf[c] = 1;
        m_new[c] = 1;
      end else if (rdhit) m_new[c] = 0;
      m_phs[c] = nphs;
      m_c[c] = ncarry;
      if (m != 0) begin
        m_a1[c] = m_a0[c];
        m_a0[c] = pin_in[m_ctr[c][4:0]];
        m_b[c] = pin_in[m_ctr[c][13:9]];
      end
      if (hit && setfrq) m_frq[c] = data;
      if (hit && setctr) begin
        m_ctr[c] = data[31:0];
        m_a0[c] = 0; m_a1[c] = 0; m_b[c] = 0;
        m_c[c] = 0; m_ovf[c] = 0;
      end
    end
  endtask

  task automatic tick();
    logic [CH-1:0] en, eo;
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      en[c] = m_new[c];
      eo[c] = m_ovf[c];
    end
    chk("phs", phs, m_phs[sel]);
    chk("cap", cap, m_cap[sel]);
    chk("cap_new", cap_new, en);
    chk("cap_ovf", cap_ovf, eo);
    chk("pin_out", pin_out, m_pins());
    res = 0; setctr = 0; setfrq = 0; setphs = 0; rd_cap = 0;
  endtask

  task automatic wr(input int kind, input int ch, input logic [W-1:0] v);
    sel = ch[0];
    data = v;
    setctr = (kind == 0);
    setfrq = (kind == 1);
    setphs = (kind == 2);
    tick();
  endtask

  initial begin
    logic [31:0] v;
    logic [W-1:0] old;
    int nev;
    bit found;

    res = 1;
    tick();
    chk("rst_phs", phs, 0);
    chk("rst_pins", pin_out, 0);
    chk("rst_flags", {cap_new, cap_ovf}, 0);

    wr(1, 0, 32'h4000_0000);
    wr(0, 0, (32'd1 << 26) | 32'd3);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("nco_pin3", pin_out[3], ((k % 4) >= 2));
    end

    wr(1, 1, 32'h8000_0000);
    wr(0, 1, (32'd3 << 26) | 32'd7);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("duty_pin7", pin_out[7], (k % 2) == 0);
    end

    res = 1;
    sel = 0;
    tick();
    chk("midrst_phs", phs, 0);
    chk("midrst_pins", pin_out, 0);
    chk("midrst_new", cap_new, 0);

    wr(1, 0, 32'd1);
    wr(0, 0, (32'd13 << 26) | 32'd2);
    for (int cyc = 0; cyc < 40; cyc++) begin
      pin_in[2] = (cyc % 10) < 5;
      tick();
    end
    chk("period_cap", cap, 10);
    chk("period_new", cap_new[0], 1);
    chk("period_ovf", cap_ovf[0], 1);

    wr(0, 0, (32'd13 << 26) | 32'd2);
    rd_cap = 1;
    tick();
    nev = 0;
    found = 0;
    for (int cyc = 40; cyc < 100 && !found; cyc++) begin
      pin_in[2] = (cyc % 10) < 5;
      sel = 0;
      if (m_capev(0)) begin
        nev++;
        if (nev == 2) begin
          old = m_phs[0];
          setphs = 1;
          data = 32'd5;
          rd_cap = 1;
          found = 1;
        end
      end
      tick();
      if (found) begin
        chk("prio_cap", cap, old);
        chk("prio_phs", phs, 5);
        chk("prio_new", cap_new[0], 1);
        chk("prio_ovf", cap_ovf[0], 0);
      end
    end
    if (!found) chk("prio_timeout", 0, 1);

    wr(1, 1, 32'd1);
    wr(0, 1, (32'd14 << 26) | 32'd5);
    for (int p = 0; p < 3; p++) begin
      for (int cyc = 0; cyc < 9; cyc++) begin
        pin_in[5] = (cyc < 3);
        sel = 1;
        tick();
      end
    end
    chk("width_phs", phs, 0);
    chk("width_cap", cap, m_cap[1]);

    wr(1, 0, 32'h3000_0000);
    wr(0, 0, (32'd2 << 26) | (32'd1 << 9) | 32'd6);
    wr(1, 1, 32'h5000_0001);
    wr(0, 1, (32'd1 << 26) | 32'd6);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("or_pin6", pin_out[6], m_phs[0][W-1] | m_phs[1][W-1]);
    end

    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 2) == 0) pin_in = pin_in ^ (32'd1 << $urandom_range(0, 31));
      sel = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 19))
        0: begin
          v = $urandom;
          v[30:26] = 5'($urandom_range(0, 20));
          data = v;
          setctr = 1;
        end
        1: begin
          data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 5)) : $urandom;
          setfrq = 1;
        end
        2: begin data = $urandom; setphs = 1; end
        3, 4: rd_cap = 1;
        5: if ($urandom_range(0, 20) == 0) res = 1;
        default: ;
      endcase
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
